mdu_iter: RTL and testbench

Iterative multiply/divide unit with architectural HI/LO registers, parametrised in operand width. It sits in the EX stage beside the single-cycle ALU and consumes the `mulalu_func`/`mulalu_sign` decode the ALU produces. It raises `busy` so the pipeline stalls until the result is committed to HI/LO. This generation adds a start/done handshake, flush-abort, MTHI/MTLO ports and defined divide-by-zero behaviour, none of which the combinational unit has.

---
 rtl/mdu_iter_pkg.sv | 20 ++
 rtl/mdu_divstep.sv | 22 ++
 rtl/mdu_iter.sv | 172 +++++++++++++++++
 tb/tb_mdu_iter.sv | 313 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mdu_iter_pkg.sv
// Shared types and encodings for the iterative multiply/divide unit.
package mdu_iter_pkg;

  localparam int W_FUNC = 2;
  localparam logic [W_FUNC-1:0] FUNC_MUL = 2'd1;
  localparam logic [W_FUNC-1:0] FUNC_DIV = 2'd2;

  typedef enum logic [1:0] {
    IDLE,
    PREP,
    CALC,
    FIX
  } mdu_state_t;

  // Iteration counter width: must hold the value WIDTH itself.
  function automatic int MDU_CNT_W(input int width);
    return $clog2(width + 1);
  endfunction

endpackage

// File: rtl/mdu_divstep.sv
// One restoring-division step: shift in the next dividend bit and subtract
// the divisor if it fits.
module mdu_divstep #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] rem_in,
  input  logic             next_bit,
  input  logic [WIDTH-1:0] divisor,
  output logic             q_bit,
  output logic [WIDTH-1:0] rem_out
);

  logic [WIDTH:0] shifted;

  always_comb begin
    shifted = {rem_in, next_bit};
    q_bit   = (shifted >= {1'b0, divisor});
    // When the subtraction is taken the result is below the divisor, so it fits WIDTH bits.
    rem_out = q_bit ? WIDTH'(shifted - {1'b0, divisor}) : shifted[WIDTH-1:0];
  end

endmodule

// File: rtl/mdu_iter.sv
// Iterative multiply/divide unit with architectural HI/LO registers.
// Divider datapath is present only when MDU_DIV_EN is defined.
module mdu_iter
  import mdu_iter_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [W_FUNC-1:0] func,
  input  logic              sign,
  input  logic [WIDTH-1:0]  source_a,
  input  logic [WIDTH-1:0]  source_b,
  input  logic              flush,
  input  logic              hi_write,
  input  logic              lo_write,
  input  logic [WIDTH-1:0]  hi_write_data,
  input  logic [WIDTH-1:0]  lo_write_data,
  output logic              busy,
  output logic              done,
  output logic [WIDTH-1:0]  hi,
  output logic [WIDTH-1:0]  lo
);

  localparam int CNT_W = MDU_CNT_W(WIDTH);

  mdu_state_t         state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [2*WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0]   op_q, op_d;
  logic [WIDTH-1:0]   hi_q, hi_d, lo_q, lo_d;
  logic               sign_q, sign_d, neg_q, neg_d, is_div_q, is_div_d;
  logic               busy_q, busy_d, done_q, done_d;

  logic [WIDTH-1:0]   raw_a, raw_b, mag_a, mag_b;
  logic [WIDTH:0]     mul_sum;
  logic [2*WIDTH-1:0] mul_next, product;

  // At acceptance the raw operands are parked in the accumulator until PREP.
  assign raw_a    = acc_q[2*WIDTH-1:WIDTH];
  assign raw_b    = acc_q[WIDTH-1:0];
  assign mag_a    = (sign_q && raw_a[WIDTH-1]) ? -raw_a : raw_a;
  assign mag_b    = (sign_q && raw_b[WIDTH-1]) ? -raw_b : raw_b;
  assign mul_sum  = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, op_q} : '0);
  assign mul_next = {mul_sum, acc_q[WIDTH-1:1]};
  assign product  = neg_q ? -acc_q : acc_q;

`ifdef MDU_DIV_EN
  logic               rem_neg_q, rem_neg_d, q_bit;
  logic [WIDTH-1:0]   rem_next, quotient, remainder;
  logic [2*WIDTH-1:0] div_next;

  mdu_divstep #(.WIDTH(WIDTH)) u_divstep (
    .rem_in   (acc_q[2*WIDTH-1:WIDTH]),
    .next_bit (acc_q[WIDTH-1]),
    .divisor  (op_q),
    .q_bit    (q_bit),
    .rem_out  (rem_next)
  );

  assign div_next  = {rem_next, acc_q[WIDTH-2:0], q_bit};
  // Divide by zero forces an all-ones quotient; the remainder path already yields the dividend.
  assign quotient  = (op_q == '0) ? '1 : (neg_q ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0]);
  assign remainder = rem_neg_q ? -acc_q[2*WIDTH-1:WIDTH] : acc_q[2*WIDTH-1:WIDTH];
`endif

  always_comb begin
    state_d  = state_q;
    cnt_d    = '0;
    acc_d    = acc_q;
    op_d     = op_q;
    sign_d   = sign_q;
    neg_d    = neg_q;
    is_div_d = is_div_q;
    hi_d     = hi_write ? hi_write_data : hi_q;
    lo_d     = lo_write ? lo_write_data : lo_q;
`ifdef MDU_DIV_EN
    rem_neg_d = rem_neg_q;
`endif
    case (state_q)
      IDLE: begin
        if (start && (func == FUNC_MUL || func == FUNC_DIV)) begin
          state_d  = PREP;
          is_div_d = (func == FUNC_DIV);
          sign_d   = sign;
          acc_d    = {source_a, source_b};
        end
      end
      PREP: begin
        state_d = CALC;
        neg_d   = sign_q & (raw_a[WIDTH-1] ^ raw_b[WIDTH-1]);
        if (is_div_q) begin
`ifdef MDU_DIV_EN
          op_d      = mag_b;
          acc_d     = {{WIDTH{1'b0}}, mag_a};
          rem_neg_d = sign_q & raw_a[WIDTH-1];
`else
          state_d = FIX;
`endif
        end else begin
          op_d  = mag_a;
          acc_d = {{WIDTH{1'b0}}, mag_b};
        end
      end
      CALC: begin
        cnt_d = cnt_q + 1'b1;
`ifdef MDU_DIV_EN
        acc_d = is_div_q ? div_next : mul_next;
`else
        acc_d = mul_next;
`endif
        if (cnt_q == CNT_W'(WIDTH - 1)) state_d = FIX;
      end
      FIX: begin
        state_d = IDLE;
        if (!flush && !is_div_q) {hi_d, lo_d} = product;
`ifdef MDU_DIV_EN
        if (!flush && is_div_q) begin
          hi_d = remainder;
          lo_d = quotient;
        end
`endif
      end
      default: state_d = IDLE;
    endcase
    if (flush) state_d = IDLE;
    if (state_d == IDLE) cnt_d = '0;
    busy_d = (state_d != IDLE);
    done_d = (state_d == FIX);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      acc_q    <= '0;
      op_q     <= '0;
      sign_q   <= 1'b0;
      neg_q    <= 1'b0;
      is_div_q <= 1'b0;
      hi_q     <= '0;
      lo_q     <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
`ifdef MDU_DIV_EN
      rem_neg_q <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      acc_q    <= acc_d;
      op_q     <= op_d;
      sign_q   <= sign_d;
      neg_q    <= neg_d;
      is_div_q <= is_div_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
`ifdef MDU_DIV_EN
      rem_neg_q <= rem_neg_d;
`endif
    end
  end

  assign busy = busy_q;
  assign done = done_q;
  assign hi   = hi_q;
  assign lo   = lo_q;

endmodule

// File: tb/tb_mdu_iter.sv
// Self-checking bench for mdu_iter: randomized MUL/DIV against an arithmetic
// reference model, plus flush, MTHI/MTLO, busy-start and async reset scenarios.
module tb_mdu_iter;
  import mdu_iter_pkg::*;

  localparam int W = 32;

  logic              clk = 1'b0;
  logic              rst, start, sign, flush, hi_write, lo_write;
  logic [W_FUNC-1:0] func;
  logic [W-1:0]      source_a, source_b, hi_write_data, lo_write_data;
  logic              busy, done;
  logic [W-1:0]      hi, lo;

  int           n_cmp = 0;
  int           n_fail = 0;
  logic [W-1:0] m_hi, m_lo;

  mdu_iter #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst), .start(start), .func(func), .sign(sign),
    .source_a(source_a), .source_b(source_b), .flush(flush),
    .hi_write(hi_write), .lo_write(lo_write),
    .hi_write_data(hi_write_data), .lo_write_data(lo_write_data),
    .busy(busy), .done(done), .hi(hi), .lo(lo)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: simulation did not finish (got timeout, want completion)");
    $fatal(1, "[TB] watchdog expired");
  end

  // Reference model: architectural HI/LO after an operation, plus done latency.
  task automatic predict(input logic [W_FUNC-1:0] f, input logic s,
                         input logic [W-1:0] a, input logic [W-1:0] b, output int lat);
    logic [63:0] p;
    longint      sa, sb;
    if (f == FUNC_MUL) begin
      if (s) begin
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        p  = 64'(sa * sb);
      end else begin
        p = {32'b0, a} * {32'b0, b};
      end
      {m_hi, m_lo} = p;
      lat = W + 2;
    end else begin
`ifdef MDU_DIV_EN
      lat = W + 2;
      if (b == 0) begin
        m_lo = '1;
        m_hi = a;
      end else if (s && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
        m_lo = 32'h8000_0000;
        m_hi = 0;
      end else if (s) begin
        m_lo = 32'($signed(a) / $signed(b));
        m_hi = 32'($signed(a) % $signed(b));
      end else begin
        m_lo = a / b;
        m_hi = a % b;
      end
`else
      lat = 2;
`endif
    end
  endtask

  // Issues one request and waits (bounded) for done; returns the done cycle
  // relative to the acceptance edge and whether busy stayed high throughout.
  task automatic run_op(input logic [W_FUNC-1:0] f, input logic s, input logic [W-1:0] a,
                        input logic [W-1:0] b, output int done_cyc, output bit busy_ok);
    start = 1'b1; func = f; sign = s; source_a = a; source_b = b;
    @(posedge clk);
    #1;
    start = 1'b0; source_a = $urandom; source_b = $urandom;
    done_cyc = -1;
    busy_ok  = 1'b1;
    for (int c = 1; c <= 60 && done_cyc < 0; c++) begin
      @(negedge clk);
      if (busy !== 1'b1) busy_ok = 1'b0;
      if (done === 1'b1) done_cyc = c;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 0; func = FUNC_MUL; sign = 0; source_a = 0; source_b = 0;
    flush = 0; hi_write = 0; lo_write = 0; hi_write_data = 0; lo_write_data = 0;
    repeat (3) @(negedge clk);
    n_cmp++; if (busy !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_busy got %b want 0", busy); end
    n_cmp++; if (done !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_done got %b want 0", done); end
    n_cmp++; if (hi !== 0) begin n_fail++; $display("[TB] FAIL reset_hi got %h want 0", hi); end
    n_cmp++; if (lo !== 0) begin n_fail++; $display("[TB] FAIL reset_lo got %h want 0", lo); end
    rst = 1'b0;
    m_hi = 0; m_lo = 0;
    @(negedge clk);
  endtask

  task automatic test_mtlo();
    logic [W-1:0] hv;
    hv = $urandom;
    lo_write = 1'b1; lo_write_data = 32'h77;
    hi_write = 1'b1; hi_write_data = hv;
    @(posedge clk); #1;
    lo_write = 1'b0; hi_write = 1'b0;
    m_lo = 32'h77; m_hi = hv;
    @(negedge clk);
    n_cmp++; if (lo !== 32'h77) begin n_fail++; $display("[TB] FAIL mtlo got %h want 00000077", lo); end
    n_cmp++; if (hi !== hv) begin n_fail++; $display("[TB] FAIL mthi got %h want %h", hi, hv); end
  endtask

  task automatic test_mul();
    logic [W-1:0] ta [2] = '{32'hFFFF_FFFD, 32'hFFFF_FFFF};
    logic [W-1:0] tb_ [2] = '{32'h0000_0007, 32'hFFFF_FFFF};
    logic         ts [2] = '{1'b1, 1'b0};
    logic [W-1:0] thi [2] = '{32'hFFFF_FFFF, 32'hFFFF_FFFE};
    logic [W-1:0] tlo [2] = '{32'hFFFF_FFEB, 32'h0000_0001};
    logic [W-1:0] a, b;
    logic         s;
    int           lat, dc;
    bit           bok;
    for (int i = 0; i < 10; i++) begin
      if (i < 2) begin a = ta[i]; b = tb_[i]; s = ts[i]; end
      else begin
        a = (i == 9) ? 32'h8000_0000 : $urandom;
        b = $urandom; s = 1'($urandom_range(0, 1));
      end
      predict(FUNC_MUL, s, a, b, lat);
      run_op(FUNC_MUL, s, a, b, dc, bok);
      n_cmp++; if (dc != lat) begin n_fail++; $display("[TB] FAIL mul%0d_latency got %0d want %0d", i, dc, lat); end
      n_cmp++; if (!bok) begin n_fail++; $display("[TB] FAIL mul%0d_busy got gap want high", i); end
      @(negedge clk);
      n_cmp++; if (hi !== m_hi) begin n_fail++; $display("[TB] FAIL mul%0d_hi got %h want %h", i, hi, m_hi); end
      n_cmp++; if (lo !== m_lo) begin n_fail++; $display("[TB] FAIL mul%0d_lo got %h want %h", i, lo, m_lo); end
      n_cmp++; if (busy !== 1'b0 || done !== 1'b0) begin n_fail++; $display("[TB] FAIL mul%0d_idle got busy=%b done=%b want 0 0", i, busy, done); end
      if (i < 2) begin
        n_cmp++; if (hi !== thi[i] || lo !== tlo[i]) begin n_fail++; $display("[TB] FAIL mul%0d_plan got %h_%h want %h_%h", i, hi, lo, thi[i], tlo[i]); end
      end
    end
  endtask

  task automatic test_div();
    logic [W-1:0] ta [3] = '{32'hFFFF_FFF9, 32'h0000_1234, 32'h8000_0000};
    logic [W-1:0] tb_ [3] = '{32'h0000_0002, 32'h0000_0000, 32'hFFFF_FFFF};
    logic         ts [3] = '{1'b1, 1'b0, 1'b1};
    logic [W-1:0] thi [3] = '{32'hFFFF_FFFF, 32'h0000_1234, 32'h0000_0000};
    logic [W-1:0] tlo [3] = '{32'hFFFF_FFFD, 32'hFFFF_FFFF, 32'h8000_0000};
    logic [W-1:0] a, b, want_hi, want_lo;
    logic         s;
    int           lat, dc;
    bit           bok;
    for (int i = 0; i < 11; i++) begin
      if (i < 3) begin a = ta[i]; b = tb_[i]; s = ts[i]; end
      else begin
        a = $urandom; s = 1'($urandom_range(0, 1));
        b = ($urandom_range(0, 2) == 0) ? 32'($urandom_range(0, 9)) : $urandom;
        if (s && $urandom_range(0, 1) == 1) b = -b;
      end
`ifdef MDU_DIV_EN
      want_hi = (i < 3) ? thi[i] : 0;
      want_lo = (i < 3) ? tlo[i] : 0;
`else
      want_hi = m_hi;
      want_lo = m_lo;
`endif
      predict(FUNC_DIV, s, a, b, lat);
      run_op(FUNC_DIV, s, a, b, dc, bok);
      n_cmp++; if (dc != lat) begin n_fail++; $display("[TB] FAIL div%0d_latency got %0d want %0d", i, dc, lat); end
      n_cmp++; if (!bok) begin n_fail++; $display("[TB] FAIL div%0d_busy got gap want high", i); end
      @(negedge clk);
      n_cmp++; if (hi !== m_hi) begin n_fail++; $display("[TB] FAIL div%0d_hi got %h want %h", i, hi, m_hi); end
      n_cmp++; if (lo !== m_lo) begin n_fail++; $display("[TB] FAIL div%0d_lo got %h want %h", i, lo, m_lo); end
      n_cmp++; if (busy !== 1'b0) begin n_fail++; $display("[TB] FAIL div%0d_idle got busy=%b want 0", i, busy); end
      if (i < 3) begin
        n_cmp++; if (hi !== want_hi || lo !== want_lo) begin n_fail++; $display("[TB] FAIL div%0d_plan got %h_%h want %h_%h", i, hi, lo, want_hi, want_lo); end
      end
    end
  endtask

  task automatic test_back_to_back();
    int lat, dc;
    bit bok;
    logic [W-1:0] a, b;
    for (int i = 0; i < 3; i++) begin
      a = $urandom; b = $urandom;
      predict(FUNC_MUL, 1'b0, a, b, lat);
      run_op(FUNC_MUL, 1'b0, a, b, dc, bok);
      n_cmp++; if (dc != lat || !bok) begin n_fail++; $display("[TB] FAIL b2b%0d got latency %0d busy_ok %0d want %0d 1", i, dc, bok, lat); end
      @(negedge clk);
      n_cmp++; if ({hi, lo} !== {m_hi, m_lo}) begin n_fail++; $display("[TB] FAIL b2b%0d_result got %h_%h want %h_%h", i, hi, lo, m_hi, m_lo); end
    end
  endtask

  task automatic test_flush();
    int dones = 0;
    hi_write = 1; hi_write_data = 32'hAA; lo_write = 1; lo_write_data = 32'h55;
    @(posedge clk); #1;
    hi_write = 0; lo_write = 0;
    m_hi = 32'hAA; m_lo = 32'h55;
    @(negedge clk);
    start = 1; func = FUNC_MUL; sign = 0; source_a = 32'h1234_5678; source_b = 32'h9ABC_DEF0;
    @(posedge clk); #1;
    start = 0;
    for (int c = 1; c <= 10; c++) begin
      @(negedge clk);
      if (done === 1'b1) dones++;
      if (c == 5) begin start = 1; source_a = 3; source_b = 5; end
      if (c == 6) start = 0;
    end
    n_cmp++; if (busy !== 1'b1) begin n_fail++; $display("[TB] FAIL flush_busy_before got %b want 1", busy); end
    flush = 1;
    @(negedge clk);
    flush = 0;
    n_cmp++; if (busy !== 1'b0) begin n_fail++; $display("[TB] FAIL flush_busy_after got %b want 0", busy); end
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (done === 1'b1 || busy !== 1'b0) dones++;
    end
    n_cmp++; if (dones != 0) begin n_fail++; $display("[TB] FAIL flush_no_done got %0d activity cycles want 0", dones); end
    n_cmp++; if (hi !== 32'hAA || lo !== 32'h55) begin n_fail++; $display("[TB] FAIL flush_hilo got %h_%h want 000000aa_00000055", hi, lo); end
  endtask

  task automatic test_start_while_busy();
    logic [W-1:0] a, b;
    int lat, dc = -1;
    a = $urandom; b = $urandom;
    predict(FUNC_MUL, 1'b1, a, b, lat);
    start = 1; func = FUNC_MUL; sign = 1; source_a = a; source_b = b;
    @(posedge clk); #1;
    start = 0;
    for (int c = 1; c <= 60 && dc < 0; c++) begin
      @(negedge clk);
      if (c == 3) begin start = 1; source_a = 32'h11; source_b = 32'h22; end
      if (c == 4) start = 0;
      if (done === 1'b1) dc = c;
    end
    n_cmp++; if (dc != lat) begin n_fail++; $display("[TB] FAIL busystart_latency got %0d want %0d", dc, lat); end
    repeat (4) @(negedge clk);
    n_cmp++; if (busy !== 1'b0) begin n_fail++; $display("[TB] FAIL busystart_queued got busy=%b want 0", busy); end
    n_cmp++; if ({hi, lo} !== {m_hi, m_lo}) begin n_fail++; $display("[TB] FAIL busystart_result got %h_%h want %h_%h", hi, lo, m_hi, m_lo); end
  endtask

  task automatic test_mthi_fix();
    logic [W-1:0] a, b;
    int lat, dc = -1;
    a = $urandom; b = $urandom;
    predict(FUNC_MUL, 1'b0, a, b, lat);
    start = 1; func = FUNC_MUL; sign = 0; source_a = a; source_b = b;
    @(posedge clk); #1;
    start = 0;
    for (int c = 1; c <= 60 && dc < 0; c++) begin
      @(negedge clk);
      if (c == 16) begin
        lo_write = 0;
        n_cmp++; if (lo !== 32'h1234_5678) begin n_fail++; $display("[TB] FAIL mtlo_calc got %h want 12345678", lo); end
      end
      if (c == 15) begin lo_write = 1; lo_write_data = 32'h1234_5678; end
      if (done === 1'b1) begin
        dc = c;
        hi_write = 1; hi_write_data = 32'hDEAD_BEEF;
      end
    end
    @(posedge clk); #1;
    hi_write = 0;
    @(negedge clk);
    n_cmp++; if (dc != lat) begin n_fail++; $display("[TB] FAIL mthifix_latency got %0d want %0d", dc, lat); end
    n_cmp++; if (hi !== m_hi) begin n_fail++; $display("[TB] FAIL mthifix_hi got %h want %h", hi, m_hi); end
    n_cmp++; if (lo !== m_lo) begin n_fail++; $display("[TB] FAIL mthifix_lo got %h want %h", lo, m_lo); end
  endtask

  task automatic test_reset_mid();
    int act = 0;
    hi_write = 1; hi_write_data = 32'hCAFE_0001; lo_write = 1; lo_write_data = 32'hCAFE_0002;
    @(posedge clk); #1;
    hi_write = 0; lo_write = 0;
    @(negedge clk);
    start = 1; func = FUNC_MUL; sign = 0; source_a = $urandom; source_b = $urandom;
    @(posedge clk); #1;
    start = 0;
    repeat (20) @(negedge clk);
    #2 rst = 1;
    #1;
    n_cmp++; if (busy !== 1'b0 || done !== 1'b0) begin n_fail++; $display("[TB] FAIL rstmid_ctrl got busy=%b done=%b want 0 0", busy, done); end
    n_cmp++; if (hi !== 0 || lo !== 0) begin n_fail++; $display("[TB] FAIL rstmid_hilo got %h_%h want 0_0", hi, lo); end
    @(negedge clk);
    rst = 0;
    m_hi = 0; m_lo = 0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (done === 1'b1 || busy !== 1'b0) act++;
    end
    n_cmp++; if (act != 0 || hi !== 0 || lo !== 0) begin n_fail++; $display("[TB] FAIL rstmid_after got activity=%0d hi=%h lo=%h want 0 0 0", act, hi, lo); end
  endtask

  initial begin
    rst = 1'b1;
    test_reset();
    test_mtlo();
    test_mul();
    test_div();
    test_back_to_back();
    test_start_while_busy();
    test_mthi_fix();
    test_flush();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
